// File: rtl/mii_mac_tx.sv
// ---------------------------------------------------------------------------
// mii_mac_tx -- MII transmit MAC framer.
//
// Takes Ethernet frame bytes from an AXI-stream slave and drives the 4-bit
// MII transmit bus. It adds the preamble and SFD, pads short frames with
// 0x00, appends the CRC-32 FCS (least-significant nibble first), and holds
// tx_en low for the inter-frame gap. All state advances only on cycles where
// mii_clk_en is high, so the block shares the system clock with the MII side.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   s_axis_tdata   frame byte, destination MAC first
//   s_axis_tvalid  byte valid
//   s_axis_tready  byte accepted when tvalid & tready (combinational, 0 when
//                  mii_clk_en is 0)
//   s_axis_tlast   last byte of frame
//   s_axis_tuser   with tlast: frame is bad, force tx_er on that byte
//   mii_clk_en     nibble strobe; all state advances only when 1
//   mii_txd        transmit nibble (registered)
//   mii_tx_en      transmit enable (registered)
//   mii_tx_er      transmit error (registered)
// ---------------------------------------------------------------------------
module mii_mac_tx #(
  parameter int DATA_WIDTH     = 4,
  parameter int ENABLE_PADDING = 1,
  parameter int MIN_FRAME_LEN  = 64,
  parameter int IFG_NIBBLES    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  mii_clk_en,
  output logic [DATA_WIDTH-1:0] mii_txd,
  output logic                  mii_tx_en,
  output logic                  mii_tx_er
);

  generate
    if (DATA_WIDTH != 4) begin : g_bad_width
      $error("mii_mac_tx: DATA_WIDTH must be 4");
    end
  endgenerate

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PAD      = 3'd3;
  localparam logic [2:0] S_FCS      = 3'd4;
  localparam logic [2:0] S_IFG      = 3'd5;
  localparam logic [2:0] S_UNDERRUN = 3'd6;
  localparam logic [2:0] S_DRAIN    = 3'd7;

  // Payload bytes (data + pad) excluding the 4-byte FCS.
  localparam logic [15:0] MIN_PAYLOAD = 16'(MIN_FRAME_LEN - 4);
  // The IDLE cycle that launches the next preamble is the last gap nibble,
  // so IFG itself runs one nibble short.
  localparam logic [15:0] IFG_LAST    = 16'(IFG_NIBBLES - 2);

  logic [2:0]            r_state;
  logic [15:0]           r_nib_cnt;    // preamble / FCS / IFG nibble counter
  logic                  r_hi;         // next payload nibble is the high one
  logic [7:0]            r_byte;       // byte currently on the wire
  logic                  r_byte_err;   // current byte carries tx_er
  logic                  r_byte_last;  // current byte ends the user data
  logic [31:0]           r_crc;
  logic [15:0]           r_byte_cnt;   // payload bytes loaded, saturating
  logic [DATA_WIDTH-1:0] r_txd;
  logic                  r_tx_en;
  logic                  r_tx_er;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_need_pad;
  logic                  w_load_data;
  logic                  w_load_pad;
  logic [7:0]            w_byte_in;
  logic [31:0]           w_fcs;
  logic [3:0]            w_fcs_nib;

  // Reflected IEEE 802.3 CRC-32, one bit per step, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // A byte is taken on the SFD cycle, on every high-nibble cycle of a
  // non-last data byte, and on every enabled cycle while draining.
  always_comb begin
    // NOTE: default first so this combinational block cannot infer a latch.
    w_ready = 1'b0;
    if (!rst && mii_clk_en) begin
      case (r_state)
        S_PREAMBLE: w_ready = (r_nib_cnt == 16'd15);
        S_DATA:     w_ready = r_hi && !r_byte_last;
        S_DRAIN:    w_ready = 1'b1;
        default:    w_ready = 1'b0;
      endcase
    end
  end

  assign s_axis_tready = w_ready;
  assign w_accept      = s_axis_tvalid && w_ready;
  assign w_need_pad    = (ENABLE_PADDING != 0) && (r_byte_cnt < MIN_PAYLOAD);
  assign w_load_data   = w_accept && (r_state != S_DRAIN);
  assign w_load_pad    = mii_clk_en && r_hi && w_need_pad &&
                         ((r_state == S_DATA && r_byte_last) || r_state == S_PAD);
  assign w_byte_in     = w_load_data ? s_axis_tdata : 8'h00;
  assign w_fcs         = ~r_crc;
  assign w_fcs_nib     = w_fcs[{r_nib_cnt[2:0], 2'b00} +: 4];

  // Byte path: the CRC and byte count advance when a data or pad byte is
  // loaded, so the CRC is already final when the last byte's high nibble
  // goes out and FCS starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      r_byte      <= '0;
      r_byte_err  <= 1'b0;
      r_byte_last <= 1'b0;
      r_crc       <= '1;
      r_byte_cnt  <= '0;
    end else if (w_load_data || w_load_pad) begin
      r_byte      <= w_byte_in;
      r_byte_err  <= w_load_data && s_axis_tlast && s_axis_tuser;
      r_byte_last <= w_load_data ? s_axis_tlast : 1'b1;
      r_crc       <= crc32_byte(r_crc, w_byte_in);
      if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
    end else if (mii_clk_en && r_state == S_IDLE) begin
      r_crc      <= '1;
      r_byte_cnt <= '0;
    end
  end

  // Framing FSM and registered MII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_nib_cnt <= '0;
      r_hi      <= 1'b0;
      r_txd     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_er   <= 1'b0;
    end else if (mii_clk_en) begin
      case (r_state)
        S_IDLE: begin
          r_txd     <= '0;
          r_tx_en   <= 1'b0;
          r_tx_er   <= 1'b0;
          r_nib_cnt <= '0;
          r_hi      <= 1'b0;
          if (s_axis_tvalid) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b0;
          if (r_nib_cnt != 16'd15) begin
            r_txd     <= 4'h5;
            r_nib_cnt <= r_nib_cnt + 16'd1;
          end else begin
            r_txd <= 4'hD;
            if (w_accept) begin
              r_hi    <= 1'b0;
              r_state <= S_DATA;
            end else begin
              // No first byte: flag the SFD nibble and discard the frame.
              r_tx_er <= 1'b1;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DATA, S_PAD: begin
          r_tx_en <= 1'b1;
          r_tx_er <= r_byte_err;
          r_txd   <= r_hi ? r_byte[7:4] : r_byte[3:0];
          r_hi    <= ~r_hi;
          if (r_hi) begin
            if (r_state == S_DATA && !r_byte_last) begin
              if (!w_accept) r_state <= S_UNDERRUN;
            end else if (w_need_pad) begin
              r_state <= S_PAD;
            end else begin
              r_state   <= S_FCS;
              r_nib_cnt <= '0;
            end
          end
        end
        S_UNDERRUN: begin
          r_txd   <= '0;
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b1;
          r_state <= S_DRAIN;
        end
        S_FCS: begin
          r_txd   <= w_fcs_nib;
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b0;
          if (r_nib_cnt[2:0] == 3'd7) begin
            r_state   <= S_IFG;
            r_nib_cnt <= '0;
          end else begin
            r_nib_cnt <= r_nib_cnt + 16'd1;
          end
        end
        S_IFG: begin
          r_txd   <= '0;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          if (r_nib_cnt >= IFG_LAST) r_state <= S_IDLE;
          else                       r_nib_cnt <= r_nib_cnt + 16'd1;
        end
        S_DRAIN: begin
          r_txd   <= '0;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          if (w_accept && s_axis_tlast) begin
            r_state   <= S_IFG;
            r_nib_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mii_txd   = r_txd;
  assign mii_tx_en = r_tx_en;
  assign mii_tx_er = r_tx_er;

endmodule

// File: tb/tb_mii_mac_tx.sv
// ---------------------------------------------------------------------------
// tb_mii_mac_tx -- self-checking bench for mii_mac_tx.
//
// A byte source feeds the AXI-stream port from a queue; a monitor records
// the MII outputs on every enabled cycle. Each frame's transmit burst is
// checked for length, preamble/SFD, data and pad nibbles, tx_er placement,
// and FCS (the CRC register run over data+FCS must land on the CRC-32
// residue 0xDEBB20E3). Table entries cover the plain frame cases; the
// underrun and mid-frame reset cases are written out by hand.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mii_mac_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic       mii_clk_en;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;

  mii_mac_tx #(
    .DATA_WIDTH(4), .ENABLE_PADDING(1), .MIN_FRAME_LEN(64), .IFG_NIBBLES(24)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .mii_clk_en    (mii_clk_en),
    .mii_txd       (mii_txd),
    .mii_tx_en     (mii_tx_en),
    .mii_tx_er     (mii_tx_er)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct { logic [3:0] nib; logic en; logic er; } samp_t;
  typedef struct {
    string      name;
    int         plen;      // user bytes in the frame
    logic [7:0] first;     // first byte value
    bit         incr;      // bytes count up from first, else all = first
    bit         bad;       // tuser on tlast
    int         div;       // mii_clk_en high one cycle in div
    int         reps;      // frames queued back to back
    int         exp_len;   // expected tx_en nibbles per frame
    int         exp_er;    // expected tx_er nibbles per frame
    int         exp_gap;   // expected tx_en-low nibbles between frames
  } vec_t;

  beat_t src_q[$];
  samp_t cap[$];
  int    run_s[$];
  int    run_l[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_div   = 1;
  int div_cnt  = 0;
  int hold_err = 0;
  int rdy_err  = 0;
  int acc_cnt  = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Clock-enable pattern and byte source, both driven on the falling edge.
  initial begin
    mii_clk_en    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    forever begin
      @(negedge clk);
      if (en_div <= 1) mii_clk_en = 1'b1;
      else begin
        mii_clk_en = (div_cnt == 0);
        div_cnt    = (div_cnt + 1) % en_div;
      end
      if (src_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[0].data;
        s_axis_tlast  = src_q[0].last;
        s_axis_tuser  = src_q[0].user;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
      end
    end
  end

  // Handshake is sampled 1 ns before the rising edge; outputs 1 ns after.
  initial begin : monitor
    logic en_s, rst_s;
    samp_t last_s, cur;
    last_s = '{4'h0, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      #4;
      en_s  = mii_clk_en;
      rst_s = rst;
      if (s_axis_tready && !mii_clk_en) rdy_err++;
      if (s_axis_tvalid && s_axis_tready && src_q.size() > 0) begin
        src_q.delete(0);
        acc_cnt++;
      end
      #2;
      cur = '{mii_txd, mii_tx_en, mii_tx_er};
      if (!rst_s) begin
        if (en_s) cap.push_back(cur);
        else if (cur != last_s) hold_err++;
      end
      last_s = cur;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_bytes(input int lo, input int hi, input logic [7:0] first,
                            input bit incr, input bit last, input bit bad);
    beat_t b;
    for (int i = lo; i <= hi; i++) begin
      b.data = incr ? 8'(first + 8'(i)) : first;
      b.last = last && (i == hi);
      b.user = bad && b.last;
      src_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int quiet = 0;
    int thr   = 60 * en_div;
    for (int cyc = 0; cyc < budget && quiet < thr; cyc++) begin
      @(negedge clk);
      if (src_q.size() == 0 && !mii_tx_en && !rst) quiet++;
      else quiet = 0;
    end
    check({name, "_complete"}, longint'(quiet >= thr), 1);
  endtask

  task automatic find_runs();
    int start = -1;
    run_s.delete();
    run_l.delete();
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i].en && start < 0) start = i;
      if (!cap[i].en && start >= 0) begin
        run_s.push_back(start);
        run_l.push_back(i - start);
        start = -1;
      end
    end
    if (start >= 0) begin
      run_s.push_back(start);
      run_l.push_back(cap.size() - start);
    end
  endtask

  task automatic check_run(input string name, input int rs, input int rl,
                           input int plen, input logic [7:0] first, input bit incr,
                           input bit bad, input int exp_len, input int exp_er);
    int pre_err = 0, data_err = 0, er_err = 0, er_cnt = 0;
    int padlen = (plen < 60) ? 60 : plen;
    int last_lo = 16 + 2 * (plen - 1);
    logic [7:0]  b;
    logic [31:0] crc = 32'hFFFFFFFF;
    check({name, "_len"}, rl, exp_len);
    for (int i = 0; i < 16; i++) begin
      if (i >= rl || cap[rs+i].nib != ((i < 15) ? 4'h5 : 4'hD)) pre_err++;
    end
    check({name, "_preamble"}, pre_err, 0);
    for (int i = 0; i < padlen; i++) begin
      b = (i < plen) ? (incr ? 8'(first + 8'(i)) : first) : 8'h00;
      if (16 + 2*i + 1 >= rl) data_err++;
      else if (cap[rs+16+2*i].nib != b[3:0] || cap[rs+16+2*i+1].nib != b[7:4]) data_err++;
    end
    check({name, "_data"}, data_err, 0);
    for (int i = 16; i + 1 < rl; i += 2) crc = crc_upd(crc, {cap[rs+i+1].nib, cap[rs+i].nib});
    check({name, "_fcs_residue"}, crc, 32'hDEBB20E3);
    for (int i = 0; i < rl; i++) begin
      if (cap[rs+i].er) er_cnt++;
      if (cap[rs+i].er != (bad && (i == last_lo || i == last_lo + 1))) er_err++;
    end
    check({name, "_er_count"}, er_cnt, exp_er);
    check({name, "_er_position"}, er_err, 0);
  endtask

  initial begin
    vec_t vecs[4];
    int   n_en;
    vecs[0] = '{"inc60",       60, 8'h00, 1'b1, 1'b0,  1, 1, 144, 0, 24};
    vecs[1] = '{"one_aa",       1, 8'hAA, 1'b0, 1'b0,  1, 2, 144, 0, 24};
    vecs[2] = '{"inc60_div10", 60, 8'h00, 1'b1, 1'b0, 10, 1, 144, 0, 24};
    vecs[3] = '{"bad64",       64, 8'h00, 1'b1, 1'b1,  1, 1, 152, 2, 24};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {mii_txd, mii_tx_en, mii_tx_er, s_axis_tready}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      en_div   = vecs[v].div;
      div_cnt  = 0;
      cap.delete();
      hold_err = 0;
      rdy_err  = 0;
      acc_cnt  = 0;
      for (int r = 0; r < vecs[v].reps; r++)
        push_bytes(0, vecs[v].plen - 1, vecs[v].first, vecs[v].incr, 1'b1, vecs[v].bad);
      wait_idle(vecs[v].name, 30000);
      find_runs();
      check({vecs[v].name, "_frames"}, run_s.size(), vecs[v].reps);
      for (int r = 0; r < run_s.size() && r < vecs[v].reps; r++)
        check_run($sformatf("%s_f%0d", vecs[v].name, r), run_s[r], run_l[r],
                  vecs[v].plen, vecs[v].first, vecs[v].incr, vecs[v].bad,
                  vecs[v].exp_len, vecs[v].exp_er);
      if (vecs[v].reps > 1 && run_s.size() > 1)
        check({vecs[v].name, "_gap"}, run_s[1] - (run_s[0] + run_l[0]), vecs[v].exp_gap);
      check({vecs[v].name, "_hold"}, hold_err, 0);
      check({vecs[v].name, "_tready_enabled_only"}, rdy_err, 0);
      check({vecs[v].name, "_accepted"}, acc_cnt, vecs[v].plen * vecs[v].reps);
    end

    // Underrun: bytes 0..40 then the source runs dry.
    @(negedge clk);
    en_div  = 1;
    cap.delete();
    acc_cnt = 0;
    push_bytes(0, 40, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_idle("underrun", 30000);
    find_runs();
    check("underrun_frames", run_s.size(), 1);
    if (run_s.size() > 0) begin
      int er_err = 0;
      check("underrun_len", run_l[0], 16 + 82 + 1);
      for (int i = 0; i < run_l[0]; i++)
        if (cap[run_s[0]+i].er != (i == run_l[0] - 1)) er_err++;
      check("underrun_er_position", er_err, 0);
    end
    check("underrun_accepted", acc_cnt, 41);
    // Remaining bytes 41..99 are drained with no transmission.
    cap.delete();
    acc_cnt = 0;
    push_bytes(41, 99, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_idle("drain", 30000);
    find_runs();
    check("drain_silent", run_s.size(), 0);
    check("drain_accepted", acc_cnt, 59);
    cap.delete();
    push_bytes(0, 59, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_idle("after_underrun", 30000);
    find_runs();
    check("after_underrun_frames", run_s.size(), 1);
    if (run_s.size() > 0)
      check_run("after_underrun", run_s[0], run_l[0], 60, 8'h00, 1'b1, 1'b0, 144, 0);

    // Reset once data nibble 50 has been sent.
    cap.delete();
    push_bytes(0, 59, 8'h00, 1'b1, 1'b1, 1'b0);
    n_en = 0;
    for (int cyc = 0; cyc < 2000 && n_en < 16 + 51; cyc++) begin
      @(negedge clk);
      n_en = 0;
      foreach (cap[k]) if (cap[k].en) n_en++;
    end
    check("reset_reached_nibble50", longint'(n_en >= 16 + 51), 1);
    rst = 1'b1;
    src_q.delete();
    @(posedge clk);
    #1;
    check("reset_midframe_outputs", {mii_txd, mii_tx_en, mii_tx_er, s_axis_tready}, 0);
    @(negedge clk);
    rst = 1'b0;
    cap.delete();
    push_bytes(0, 59, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_idle("after_reset", 30000);
    find_runs();
    check("after_reset_frames", run_s.size(), 1);
    if (run_s.size() > 0)
      check_run("after_reset", run_s[0], run_l[0], 60, 8'h00, 1'b1, 1'b0, 144, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
